// File: rtl/multiply_and_add_unit_if.sv
// Operand/result bundle for one multiply-accumulate lane.
// The master drives operands and the slave (the MAC) returns the result.
interface multiply_and_add_unit_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WEIGHT_WIDTH = 8
);
    logic                    input_enable;
    logic [DATA_WIDTH-1:0]   add_value;
    logic [DATA_WIDTH-1:0]   input_value;
    logic [WEIGHT_WIDTH-1:0] weight_value;
    logic [DATA_WIDTH-1:0]   output_value;
    logic                    output_enable;

    modport master (
        output input_enable, add_value, input_value, weight_value,
        input  output_value, output_enable
    );

    modport slave (
        input  input_enable, add_value, input_value, weight_value,
        output output_value, output_enable
    );
endinterface

// File: rtl/multiply_and_add_unit.sv
// Registered unsigned multiply-accumulate: output = add + input * weight, wrapping.
// Idle cycles drive a zero result so chained adders see nothing from this lane.
module multiply_and_add_unit #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned PIPE_STAGES  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multiply_and_add_unit_if.slave bus
);
    localparam int unsigned DW = DATA_WIDTH;

    logic [DW-1:0] product_c;
    logic [DW-1:0] result_q;
    logic          enable_q;

    // Only the low DW bits of the full product ever reach the output.
    assign product_c = bus.input_value * DW'(bus.weight_value);

    if (PIPE_STAGES == 1) begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                result_q <= '0;
                enable_q <= 1'b0;
            end else begin
                enable_q <= bus.input_enable;
                result_q <= bus.input_enable ? (bus.add_value + product_c) : '0;
            end
        end
    end else begin : g_double
        logic [DW-1:0] product_q;
        logic [DW-1:0] add_q;
        logic          enable_s1_q;

        // Stage 1 gates operands with the enable so idle inputs never leak forward.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                product_q   <= '0;
                add_q       <= '0;
                enable_s1_q <= 1'b0;
            end else begin
                enable_s1_q <= bus.input_enable;
                product_q   <= bus.input_enable ? product_c     : '0;
                add_q       <= bus.input_enable ? bus.add_value : '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                result_q <= '0;
                enable_q <= 1'b0;
            end else begin
                enable_q <= enable_s1_q;
                result_q <= enable_s1_q ? (add_q + product_q) : '0;
            end
        end
    end

    assign bus.output_value  = result_q;
    assign bus.output_enable = enable_q;
endmodule

// File: tb/tb_multiply_and_add_unit.sv
// Directed checks on a single-stage MAC plus a streaming run on a two-stage MAC.
module tb_multiply_and_add_unit;
    localparam int unsigned DW = 32;
    localparam int unsigned WW = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    multiply_and_add_unit_if #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) bus1 ();
    multiply_and_add_unit_if #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) bus2 ();

    multiply_and_add_unit #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .PIPE_STAGES(1)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1.slave)
    );

    multiply_and_add_unit #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .PIPE_STAGES(2)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic en, input logic [DW-1:0] a, input logic [DW-1:0] i,
                          input logic [WW-1:0] w);
        bus1.input_enable = en;
        bus1.add_value    = a;
        bus1.input_value  = i;
        bus1.weight_value = w;
    endtask

    // Directed vectors: enable, add, input, weight, expected value, expected enable
    localparam int NVEC = 7;
    logic          v_en  [NVEC] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [DW-1:0] v_add [NVEC] = '{32'd10, 32'd99, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678, 32'd5};
    logic [DW-1:0] v_in  [NVEC] = '{32'd7, 32'd7, 32'd2, 32'd1, 32'h8000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    logic [WW-1:0] v_w   [NVEC] = '{8'd3, 8'd3, 8'hFF, 8'd1, 8'd2, 8'd0, 8'hFF};
    logic [DW-1:0] v_exp [NVEC] = '{32'd31, 32'd0, 32'd510, 32'd0, 32'd0, 32'h1234_5678, 32'hFFFF_FF06};
    logic          v_oen [NVEC] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    logic [DW-1:0] pipe_val;
    logic          pipe_en;
    logic [DW-1:0] cur_val;
    logic          cur_en;

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive1(1'b0, '0, '0, '0);
        bus2.input_enable = 1'b0;
        bus2.add_value    = '0;
        bus2.input_value  = '0;
        bus2.weight_value = '0;

        #2;
        check("reset_value", 64'(bus1.output_value), 64'd0);
        check("reset_enable", 64'(bus1.output_enable), 64'd0);
        check("reset_value_p2", 64'(bus2.output_value), 64'd0);
        #10 rst_n = 1'b1;

        for (int k = 0; k < NVEC; k++) begin
            drive1(v_en[k], v_add[k], v_in[k], v_w[k]);
            step();
            check($sformatf("vec%0d_value", k), 64'(bus1.output_value), 64'(v_exp[k]));
            check($sformatf("vec%0d_enable", k), 64'(bus1.output_enable), 64'(v_oen[k]));
        end

        // Asynchronous reset between edges while enable stays high
        drive1(1'b1, 32'd10, 32'd7, 8'd3);
        step();
        check("pre_reset_value", 64'(bus1.output_value), 64'd31);
        rst_n = 1'b0;
        #1;
        check("async_reset_value", 64'(bus1.output_value), 64'd0);
        check("async_reset_enable", 64'(bus1.output_enable), 64'd0);
        #2 rst_n = 1'b1;
        drive1(1'b1, 32'd100, 32'd6, 8'd4);
        step();
        check("post_reset_value", 64'(bus1.output_value), 64'd124);
        check("post_reset_enable", 64'(bus1.output_enable), 64'd1);
        drive1(1'b0, '0, '0, '0);

        // Two-stage streaming against a one-deep delay model
        pipe_val = '0;
        pipe_en  = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            bus2.input_enable = ($urandom_range(0, 3) != 0);
            bus2.add_value    = $urandom;
            bus2.input_value  = $urandom;
            bus2.weight_value = WW'($urandom);
            cur_en  = bus2.input_enable;
            cur_val = cur_en ? (bus2.add_value + bus2.input_value * 32'(bus2.weight_value)) : 32'd0;
            step();
            check("stream_value", 64'(bus2.output_value), 64'(pipe_val));
            check("stream_enable", 64'(bus2.output_enable), 64'(pipe_en));
            pipe_val = cur_val;
            pipe_en  = cur_en;
        end
        bus2.input_enable = 1'b0;
        step();
        check("drain_value", 64'(bus2.output_value), 64'(pipe_val));
        check("drain_enable", 64'(bus2.output_enable), 64'(pipe_en));
        step();
        check("idle_value_p2", 64'(bus2.output_value), 64'd0);
        check("idle_enable_p2", 64'(bus2.output_enable), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
